// File: rtl/vm_pkg.sv
// Shared encodings for the change dispenser: status, coin codes, coin values and FSM states.
package vm_pkg;

    typedef enum logic [1:0] {
        STATUS_IDLE   = 2'b00,
        STATUS_VEND   = 2'b01,
        STATUS_CHANGE = 2'b10,
        STATUS_REFUND = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } coin_e;

    localparam logic [7:0] VALUE_5  = 8'd5;
    localparam logic [7:0] VALUE_10 = 8'd10;
    localparam logic [7:0] VALUE_25 = 8'd25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE,
        S_FAULT
    } state_e;

    function automatic logic [7:0] coin_value(input coin_e coin);
        case (coin)
            COIN_5:  return VALUE_5;
            COIN_10: return VALUE_10;
            COIN_25: return VALUE_25;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Coin-request handshake between the change dispenser (master) and the hopper (slave).
interface vm_change_dispenser_if;
    import vm_pkg::*;

    logic  change_valid;
    coin_e change_coin;
    logic  change_ack;

    modport master (output change_valid, output change_coin, input change_ack);
    modport slave  (input change_valid, input change_coin, output change_ack);

endinterface

// File: rtl/vm_change_select.sv
// Greedy denomination choice: largest coin in stock whose value fits the remaining amount.
module vm_change_select
    import vm_pkg::*;
(
    input  logic [7:0] remaining,
    input  logic [3:0] stock_5,
    input  logic [3:0] stock_10,
    input  logic [3:0] stock_25,
    output logic       found,
    output coin_e      coin
);

    always_comb begin
        found = 1'b0;
        coin  = COIN_NONE;
        if (stock_25 != '0 && remaining >= VALUE_25) begin
            found = 1'b1;
            coin  = COIN_25;
        end else if (stock_10 != '0 && remaining >= VALUE_10) begin
            found = 1'b1;
            coin  = COIN_10;
        end else if (stock_5 != '0 && remaining >= VALUE_5) begin
            found = 1'b1;
            coin  = COIN_5;
        end
    end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: pays out a latched balance coin by coin over the hopper handshake,
// tracks per-denomination tube stock, and latches a sticky fault on hopper timeout.
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int STOCK_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            status,
    input  logic [7:0]            balance,
    input  logic                  refill_valid,
    input  logic [1:0]            refill_coin,
    input  logic [3:0]            refill_count,
    vm_change_dispenser_if.master hopper,
    output logic                  busy,
    output logic                  change_done,
    output logic [7:0]            shortfall,
    output logic                  fault
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_e        state, next_state;
    status_e       status_q;
    logic [7:0]    remaining;
    logic [3:0]    stock_5, stock_10, stock_25;
    logic [CW-1:0] tmo_cnt;
    logic          trigger, ack_hit, timeout, refill_ok, sel_found;
    coin_e         sel_coin;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 5'(STOCK_MAX)) ? 4'(STOCK_MAX) : s[3:0];
    endfunction

    // Only an entry into change-due/refund counts; a held status never retriggers.
    assign trigger   = (status_q inside {STATUS_IDLE, STATUS_VEND}) &&
                       (status_e'(status) inside {STATUS_CHANGE, STATUS_REFUND});
    assign ack_hit   = (state == S_ISSUE) && hopper.change_valid && hopper.change_ack;
    assign timeout   = (state == S_ISSUE) && !ack_hit && (tmo_cnt == CW'(ACK_TIMEOUT - 1));
    assign refill_ok = (state == S_IDLE) && refill_valid && (coin_e'(refill_coin) != COIN_NONE);
    assign busy      = !(state inside {S_IDLE, S_FAULT});

    vm_change_select u_select (
        .remaining (remaining),
        .stock_5   (stock_5),
        .stock_10  (stock_10),
        .stock_25  (stock_25),
        .found     (sel_found),
        .coin      (sel_coin)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (trigger) next_state = S_SELECT;
            S_SELECT: next_state = sel_found ? S_ISSUE : S_DONE;
            S_ISSUE: begin
                if (ack_hit)      next_state = S_SELECT;
                else if (timeout) next_state = S_FAULT;
            end
            S_DONE:   next_state = S_IDLE;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q            <= STATUS_IDLE;
            remaining           <= '0;
            stock_5             <= '0;
            stock_10            <= '0;
            stock_25            <= '0;
            tmo_cnt             <= '0;
            hopper.change_valid <= 1'b0;
            hopper.change_coin  <= COIN_NONE;
            change_done         <= 1'b0;
            shortfall           <= '0;
            fault               <= 1'b0;
        end else begin
            status_q    <= status_e'(status);
            change_done <= 1'b0;
            if (state == S_IDLE && trigger)
                remaining <= balance;
            // Refill lands in the trigger cycle too, so the first SELECT sees it.
            if (refill_ok) begin
                case (coin_e'(refill_coin))
                    COIN_5:  stock_5  <= sat_add(stock_5,  refill_count);
                    COIN_10: stock_10 <= sat_add(stock_10, refill_count);
                    COIN_25: stock_25 <= sat_add(stock_25, refill_count);
                    default: ;
                endcase
            end
            if (state == S_SELECT) begin
                tmo_cnt <= '0;
                if (sel_found) begin
                    hopper.change_valid <= 1'b1;
                    hopper.change_coin  <= sel_coin;
                end else begin
                    change_done <= 1'b1;
                    shortfall   <= remaining;
                end
            end
            if (state == S_ISSUE) begin
                if (ack_hit) begin
                    hopper.change_valid <= 1'b0;
                    remaining <= remaining - coin_value(hopper.change_coin);
                    case (hopper.change_coin)
                        COIN_5:  stock_5  <= stock_5  - 4'd1;
                        COIN_10: stock_10 <= stock_10 - 4'd1;
                        COIN_25: stock_25 <= stock_25 - 4'd1;
                        default: ;
                    endcase
                end else if (timeout) begin
                    hopper.change_valid <= 1'b0;
                    fault               <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: a hopper model acks each request one cycle after it appears.
module tb_vm_change_dispenser;
    import vm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] status;
    logic [7:0] balance;
    logic       refill_valid;
    logic [1:0] refill_coin;
    logic [3:0] refill_count;
    logic       busy, change_done, fault;
    logic [7:0] shortfall;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_coins;
    int         got_n, first_valid, done_cyc;
    bit         unstable;

    vm_change_dispenser_if hop();

    vm_change_dispenser #(.ACK_TIMEOUT(15), .STOCK_MAX(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .status       (status),
        .balance      (balance),
        .refill_valid (refill_valid),
        .refill_coin  (refill_coin),
        .refill_count (refill_count),
        .hopper       (hop),
        .busy         (busy),
        .change_done  (change_done),
        .shortfall    (shortfall),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        status = 2'b00;
        balance = '0;
        refill_valid = 1'b0;
        refill_coin = 2'b00;
        refill_count = '0;
        hop.change_ack = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic do_refill(input logic [1:0] coin, input logic [3:0] count);
        refill_valid = 1'b1;
        refill_coin  = coin;
        refill_count = count;
        tick;
        refill_valid = 1'b0;
    endtask

    // Cycle 0 is the cycle in which the trigger status is driven.
    task automatic collect(input int budget);
        int    hold;
        int    cyc;
        coin_e seen;
        got_coins = '0;
        got_n = 0;
        first_valid = -1;
        done_cyc = -1;
        unstable = 1'b0;
        hold = 0;
        cyc = 0;
        seen = COIN_NONE;
        while (done_cyc < 0 && cyc < budget) begin
            if (change_done) begin
                done_cyc = cyc;
            end else begin
                if (hop.change_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (hold == 0) begin
                        seen = hop.change_coin;
                        hold = 1;
                    end else begin
                        if (hop.change_coin !== seen) unstable = 1'b1;
                        hop.change_ack = 1'b1;
                        if (got_n < 4) got_coins[got_n*2 +: 2] = hop.change_coin;
                        got_n++;
                        hold = 0;
                    end
                end
                tick;
                hop.change_ack = 1'b0;
                refill_valid = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        apply_reset;
        checks++; if (hop.change_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", hop.change_valid); end
        checks++; if (hop.change_coin !== COIN_NONE) begin errors++; $display("FAIL reset_coin: got %0b expected 00", hop.change_coin); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (change_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", change_done); end
        checks++; if (shortfall !== 8'd0) begin errors++; $display("FAIL reset_shortfall: got %0d expected 0", shortfall); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
        checks++; if ({dut.stock_25, dut.stock_10, dut.stock_5} !== 12'h000) begin errors++; $display("FAIL reset_stock: got %h expected 000", {dut.stock_25, dut.stock_10, dut.stock_5}); end
    endtask

    task automatic test_basic_payout;
        do_refill(2'b11, 4'd4);
        do_refill(2'b10, 4'd4);
        do_refill(2'b01, 4'd4);
        balance = 8'd40;
        status = 2'b10;
        collect(60);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL basic_count: got %0d expected 3", got_n); end
        checks++; if (got_coins !== 8'h1B) begin errors++; $display("FAIL basic_coins: got %h expected 1b", got_coins); end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", first_valid); end
        checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL basic_stable: got %0b expected 0", unstable); end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc); end
        tick;
        checks++; if (change_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %0b expected 0", change_done); end
        checks++; if (shortfall !== 8'd0) begin errors++; $display("FAIL basic_shortfall: got %0d expected 0", shortfall); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %0b expected 0", busy); end
        checks++; if ({dut.stock_25, dut.stock_10, dut.stock_5} !== 12'h333) begin errors++; $display("FAIL basic_stock: got %h expected 333", {dut.stock_25, dut.stock_10, dut.stock_5}); end
        status = 2'b00;
        tick;
    endtask

    task automatic test_greedy_shortfall;
        apply_reset;
        do_refill(2'b10, 4'd1);
        do_refill(2'b01, 4'd2);
        balance = 8'd30;
        status = 2'b11;
        collect(60);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL greedy_count: got %0d expected 3", got_n); end
        checks++; if (got_coins !== 8'h16) begin errors++; $display("FAIL greedy_coins: got %h expected 16", got_coins); end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL greedy_done_cycle: got %0d expected 11", done_cyc); end
        tick;
        checks++; if (shortfall !== 8'd10) begin errors++; $display("FAIL greedy_shortfall: got %0d expected 10", shortfall); end
        checks++; if ({dut.stock_25, dut.stock_10, dut.stock_5} !== 12'h000) begin errors++; $display("FAIL greedy_stock: got %h expected 000", {dut.stock_25, dut.stock_10, dut.stock_5}); end
        status = 2'b00;
        tick;
    endtask

    task automatic test_zero_balance;
        bit activity;
        balance = 8'd0;
        status = 2'b11;
        collect(20);
        checks++; if (first_valid !== -1) begin errors++; $display("FAIL zero_valid: got first valid at %0d expected none", first_valid); end
        checks++; if (done_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 2", done_cyc); end
        tick;
        checks++; if (shortfall !== 8'd0) begin errors++; $display("FAIL zero_shortfall: got %0d expected 0", shortfall); end
        activity = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy || change_done || hop.change_valid) activity = 1'b1;
            tick;
        end
        checks++; if (activity !== 1'b0) begin errors++; $display("FAIL held_status_retrigger: got activity %0b expected 0", activity); end
        status = 2'b00;
        tick;
    endtask

    task automatic test_refill_saturation;
        do_refill(2'b10, 4'd12);
        do_refill(2'b10, 4'd12);
        checks++; if (dut.stock_10 !== 4'd15) begin errors++; $display("FAIL refill_saturate: got %0d expected 15", dut.stock_10); end
        balance = 8'd0;
        status = 2'b10;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL refill_busy_state: got %0b expected 1", busy); end
        refill_valid = 1'b1;
        refill_coin = 2'b10;
        refill_count = 4'd3;
        tick;
        refill_valid = 1'b0;
        checks++; if (dut.stock_10 !== 4'd15) begin errors++; $display("FAIL refill_while_busy: got %0d expected 15", dut.stock_10); end
        status = 2'b00;
        tick;
        tick;
        tick;
    endtask

    task automatic test_simultaneous;
        balance = 8'd5;
        status = 2'b10;
        refill_valid = 1'b1;
        refill_coin = 2'b01;
        refill_count = 4'd1;
        collect(30);
        checks++; if (got_n !== 1) begin errors++; $display("FAIL simul_count: got %0d expected 1", got_n); end
        checks++; if (got_coins !== 8'h01) begin errors++; $display("FAIL simul_coin: got %h expected 01", got_coins); end
        tick;
        checks++; if (shortfall !== 8'd0) begin errors++; $display("FAIL simul_shortfall: got %0d expected 0", shortfall); end
        checks++; if (dut.stock_5 !== 4'd0) begin errors++; $display("FAIL simul_stock: got %0d expected 0", dut.stock_5); end
        status = 2'b00;
        tick;
    endtask

    task automatic test_timeout_fault;
        int  valid_cycles;
        int  fault_cyc;
        bit  activity;
        do_refill(2'b01, 4'd1);
        balance = 8'd5;
        status = 2'b10;
        valid_cycles = 0;
        fault_cyc = -1;
        for (int c = 0; c < 40 && fault_cyc < 0; c++) begin
            if (hop.change_valid) valid_cycles++;
            if (fault) fault_cyc = c;
            else tick;
        end
        checks++; if (valid_cycles !== 15) begin errors++; $display("FAIL timeout_valid_len: got %0d expected 15", valid_cycles); end
        checks++; if (fault_cyc !== 17) begin errors++; $display("FAIL timeout_fault_cycle: got %0d expected 17", fault_cyc); end
        checks++; if (hop.change_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid_drop: got %0b expected 0", hop.change_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fault_busy: got %0b expected 0", busy); end
        status = 2'b00;
        tick;
        status = 2'b11;
        refill_valid = 1'b1;
        refill_coin = 2'b01;
        refill_count = 4'd2;
        activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || change_done || hop.change_valid) activity = 1'b1;
            tick;
            refill_valid = 1'b0;
        end
        checks++; if (activity !== 1'b0) begin errors++; $display("FAIL fault_ignores_trigger: got activity %0b expected 0", activity); end
        checks++; if (dut.stock_5 !== 4'd1) begin errors++; $display("FAIL fault_ignores_refill: got %0d expected 1", dut.stock_5); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %0b expected 1", fault); end
    endtask

    task automatic test_reset_mid_handshake;
        bit seen_valid;
        apply_reset;
        do_refill(2'b11, 4'd2);
        balance = 8'd25;
        status = 2'b10;
        seen_valid = 1'b0;
        for (int c = 0; c < 10 && !seen_valid; c++) begin
            if (hop.change_valid) seen_valid = 1'b1;
            else tick;
        end
        checks++; if (seen_valid !== 1'b1) begin errors++; $display("FAIL midrst_request: got valid %0b expected 1", seen_valid); end
        rst = 1'b1;
        status = 2'b00;
        tick;
        checks++; if (hop.change_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b expected 0", hop.change_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if ({dut.stock_25, dut.stock_10, dut.stock_5} !== 12'h000) begin errors++; $display("FAIL midrst_stock: got %h expected 000", {dut.stock_25, dut.stock_10, dut.stock_5}); end
        rst = 1'b0;
        tick;
    endtask

    initial begin
        hop.change_ack = 1'b0;
        test_reset;
        test_basic_payout;
        test_greedy_shortfall;
        test_zero_balance;
        test_refill_saturation;
        test_simultaneous;
        test_timeout_fault;
        test_reset_mid_handshake;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/vm_change_dispenser.md
VM_CHANGE_DISPENSER -- requirements
Module: vm_change_dispenser

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, maximum cycles change_valid is held without change_ack before a fault.
REQ-002 Parameter: STOCK_MAX, default 15, saturation limit of each coin-tube counter (4-bit).
REQ-003 Ports: clk  in  1  the single clock; all logic on its rising edge.
REQ-004 Ports: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: status  in  2  vending-machine status; 00 idle, 01 vending, 10 change due, 11 refund.
REQ-006 Ports: balance  in  8  amount owed to the customer, in units; sampled on trigger.
REQ-007 Ports: refill_valid  in  1  service refill strobe.
REQ-008 Ports: refill_coin  in  2  denomination being refilled; 01=5, 10=10, 11=25; 00 is invalid.
REQ-009 Ports: refill_count  in  4  number of coins added.
REQ-010 Ports: change_valid  out  1  coin request to the hopper.
REQ-011 Ports: change_coin  out  2  denomination requested; same code as refill_coin.
REQ-012 Ports: change_ack  in  1  hopper has ejected the requested coin.
REQ-013 Ports: busy  out  1  high in every state except IDLE and FAULT.
REQ-014 Ports: change_done  out  1  one-cycle pulse at the end of each payout.
REQ-015 Ports: shortfall  out  8  units not paid out by the last payout; held until the next payout ends.
REQ-016 Ports: fault  out  1  sticky hopper-timeout flag.

Function
REQ-017 Trigger:
- status enters 10 or 11 from 00 or 01, detected against a registered copy of the previous status.
- A status held at 10 or 11 shall not retrigger.
REQ-018 FSM states: IDLE, SELECT, ISSUE, DONE, FAULT.
REQ-019 IDLE:
- On trigger, latch balance into 8-bit remaining, then go to SELECT.
- Without trigger, stay in IDLE.
REQ-020 SELECT (one cycle):
- Pick the largest denomination with value <= remaining and stock > 0, then go to ISSUE.
- If remaining = 0, or no denomination qualifies, go to DONE.
REQ-021 ISSUE:
- Drive change_valid = 1 and change_coin = selected code, both registered.
- The first change_valid appears 2 cycles after the trigger cycle.
REQ-022 Handshake:
- change_valid and change_coin shall stay stable until the cycle change_ack = 1.
- In that cycle: remaining -= value, that denomination's stock -= 1, change_valid drops next cycle, return to SELECT.
- change_ack while change_valid = 0 shall be ignored.
REQ-023 Arithmetic: subtraction is never applied when value > remaining, so no underflow shall occur.
REQ-024 DONE:
- Pulse change_done for exactly one cycle.
- Load shortfall with remaining.
- Go to IDLE.
REQ-025 Timeout:
- A counter counts cycles in ISSUE without change_ack.
- On reaching ACK_TIMEOUT: drop change_valid, set fault = 1, enter FAULT.
REQ-026 FAULT: terminal until rst; triggers and refills ignored; change_done not pulsed.
REQ-027 Refill:
- Accepted only in IDLE when refill_valid = 1 and refill_coin != 00.
- stock[coin] += refill_count, saturating at STOCK_MAX.
- Refill in any other state shall be ignored.
REQ-028 Simultaneous trigger and refill in IDLE: the refill is applied and the trigger is accepted; the refilled stock is visible to the first SELECT.

Reset
REQ-029 On rst:
- Outputs: change_valid=0, change_coin=00, busy=0, change_done=0, shortfall=0, fault=0.
- All three stocks = 0; remaining = 0; timeout counter = 0; previous status = 00; state = IDLE.
REQ-030 rst in any state, including mid-handshake, shall take effect at the next edge; any pending coin request is abandoned.

Structure
REQ-031 Package vm_pkg shall hold:
- status encoding and coin-code enums;
- coin values 5/10/25;
- FSM state enum.
REQ-032 The greedy denomination choice shall be one combinational sub-module, vm_change_select (inputs: remaining and three stocks; outputs: found and coin code).

Verification
REQ-033 Refill 4 coins each of 25, 10 and 5; status 00->10 with balance 40 -> coins 25, 10, 5 in order; change_done; shortfall 0; stocks 3/3/3.
REQ-034 Stock 25:0, 10:1, 5:2; balance 30, status 00->11 -> coins 10, 5, 5; shortfall 10.
REQ-035 Trigger with balance 5 and stock 5:1, change_ack never asserted -> after 15 cycles change_valid=0 and fault=1; a later trigger produces no activity until rst.
REQ-036 status 00->11 with balance 0 -> change_done 2 cycles after trigger; no change_valid; shortfall 0.
REQ-037 Refill 10-unit coins with count 12 twice -> stock 15; refill while busy -> stock unchanged.
REQ-038 rst asserted while change_valid=1 awaiting ack -> next cycle change_valid=0, busy=0, all stocks 0.
